// File: rtl/shreg_sequencer_pkg.sv
// Shared encodings for the shift-register sequencer: command bus values, FSM states and
// counter sizing. Both the sequencer and the shift register import this package.
package shreg_sequencer_pkg;

   localparam int unsigned CntWidth = 8;

   // Command bus seen by the universal shift register.
   typedef enum logic [1:0] {
      SelHold = 2'b00,
      SelShr  = 2'b01,
      SelShl  = 2'b10,
      SelLoad = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StLoad  = 2'b01,
      StShift = 2'b10,
      StDone  = 2'b11
   } state_e;

   function automatic sel_e shift_sel(input logic dir);
      return dir ? SelShl : SelShr;
   endfunction

endpackage

// File: rtl/shreg_seq_counter.sv
// Shift-cycle counter: clear has priority over enable; tc_o flags the last shift cycle.
module shreg_seq_counter
   import shreg_sequencer_pkg::*;
#(
   parameter int unsigned SHIFTS = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   // With SHIFTS = 0 the sequencer never enters SHIFT, so the wrapped value is never compared.
   localparam logic [CntWidth-1:0] TcValue = CntWidth'(SHIFTS - 1);

   logic [CntWidth-1:0] count_q;
   logic [CntWidth-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == TcValue);

endmodule

// File: rtl/shreg_sequencer.sv
// Command sequencer for the universal shift register: per accepted byte it issues one load,
// SHIFTS shift cycles in the captured direction, then a hold cycle carrying a Done pulse.
module shreg_sequencer
   import shreg_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SHIFTS = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] InData,
   input  logic             InValid,
   input  logic             InDir,
   output logic             InReady,
   input  logic             Abort,
   output logic [WIDTH-1:0] Din,
   output logic [1:0]       Sel,
   output logic             Busy,
   output logic             Done
);

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic             dir_q;
   logic             tc;
   logic             cnt_clr;
   logic             cnt_en;

   // The count only runs while shifting; any exit from SHIFT leaves it cleared for the next byte.
   assign cnt_en  = (state_q == StShift);
   assign cnt_clr = (state_q != StShift) || Abort || tc;

   shreg_seq_counter #(
      .SHIFTS (SHIFTS)
   ) u_counter (
      .clk_i  (Clk),
      .rst_ni (Rst_n),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .tc_o   (tc)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= StIdle;
         data_q  <= '0;
         dir_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               // Abort is deliberately ignored here so a simultaneous valid byte is taken.
               if (InValid) begin
                  state_q <= StLoad;
                  data_q  <= InData;
                  dir_q   <= InDir;
               end
            end
            StLoad: begin
               if (Abort) begin
                  state_q <= StIdle;
               end else if (SHIFTS == 0) begin
                  state_q <= StDone;
               end else begin
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (Abort) begin
                  state_q <= StIdle;
               end else if (tc) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Moore decode: outputs depend only on state and the captured byte/direction.
   always_comb begin
      InReady = 1'b0;
      Sel     = SelHold;
      Din     = '0;
      Busy    = 1'b0;
      Done    = 1'b0;
      case (state_q)
         StIdle: begin
            InReady = 1'b1;
         end
         StLoad: begin
            Sel  = SelLoad;
            Din  = data_q;
            Busy = 1'b1;
         end
         StShift: begin
            Sel  = shift_sel(dir_q);
            Busy = 1'b1;
         end
         StDone: begin
            Done = 1'b1;
         end
         default: begin
            InReady = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_shreg_sequencer.sv
// Directed bench for shreg_sequencer: three builds (SHIFTS = 8, 3, 0) each driving a small
// behavioural shift-register model so loaded/shifted data can be checked end to end.
module tb_shreg_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid [3];
   logic       in_dir   [3];
   logic       abort    [3];
   logic [7:0] in_data  [3];
   logic       in_ready [3];
   logic       busy     [3];
   logic       done     [3];
   logic [7:0] din      [3];
   logic [1:0] sel      [3];
   logic [7:0] q        [3];

   int checks = 0;
   int passes = 0;
   bit bad_sel_seen = 1'b0;

   shreg_sequencer #(.WIDTH(8), .SHIFTS(8)) u_dut8 (
      .Clk(clk), .Rst_n(rst_n), .InData(in_data[0]), .InValid(in_valid[0]), .InDir(in_dir[0]),
      .InReady(in_ready[0]), .Abort(abort[0]), .Din(din[0]), .Sel(sel[0]), .Busy(busy[0]),
      .Done(done[0])
   );

   shreg_sequencer #(.WIDTH(8), .SHIFTS(3)) u_dut3 (
      .Clk(clk), .Rst_n(rst_n), .InData(in_data[1]), .InValid(in_valid[1]), .InDir(in_dir[1]),
      .InReady(in_ready[1]), .Abort(abort[1]), .Din(din[1]), .Sel(sel[1]), .Busy(busy[1]),
      .Done(done[1])
   );

   shreg_sequencer #(.WIDTH(8), .SHIFTS(0)) u_dut0 (
      .Clk(clk), .Rst_n(rst_n), .InData(in_data[2]), .InValid(in_valid[2]), .InDir(in_dir[2]),
      .InReady(in_ready[2]), .Abort(abort[2]), .Din(din[2]), .Sel(sel[2]), .Busy(busy[2]),
      .Done(done[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural universal shift register, zero shifted in.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            q[i] <= 8'h00;
         end else begin
            case (sel[i])
               2'b01:   q[i] <= {1'b0, q[i][7:1]};
               2'b10:   q[i] <= {q[i][6:0], 1'b0};
               2'b11:   q[i] <= din[i];
               default: q[i] <= q[i];
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (sel[2] == 2'b01 || sel[2] == 2'b10) bad_sel_seen <= 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      @(negedge clk);
      checks++; if (sel[0] !== 2'b00) $display("FAIL reset_sel: got %b required 00", sel[0]); else passes++;
      checks++; if (din[0] !== 8'h00) $display("FAIL reset_din: got %h required 00", din[0]); else passes++;
      checks++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy[0]); else passes++;
      checks++; if (done[0] !== 1'b0) $display("FAIL reset_done: got %b required 0", done[0]); else passes++;
      checks++; if (in_ready[0] !== 1'b1) $display("FAIL reset_ready: got %b required 1", in_ready[0]); else passes++;
      // Start a byte and pull reset while it is shifting.
      @(posedge clk); #1; in_data[0] = 8'hFF; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (sel[0] !== 2'b01) $display("FAIL midshift_sel: got %b required 01", sel[0]); else passes++;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (sel[0] !== 2'b00 || din[0] !== 8'h00 || busy[0] !== 1'b0 || done[0] !== 1'b0 ||
          in_ready[0] !== 1'b1)
         $display("FAIL midshift_reset: got sel=%b din=%h busy=%b done=%b ready=%b required 00 00 0 0 1",
                  sel[0], din[0], busy[0], done[0], in_ready[0]);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (sel[0] !== 2'b00 || in_ready[0] !== 1'b1)
         $display("FAIL after_reset_idle: got sel=%b ready=%b required 00 1", sel[0], in_ready[0]);
      else passes++;
   endtask

   task automatic test_right();
      int         ready_low;
      logic [1:0] exp_sel;
      logic [7:0] exp_din;
      logic       exp_done;
      logic       exp_busy;
      ready_low = 0;
      @(posedge clk); #1; in_data[0] = 8'h4A; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         exp_sel  = (c == 1) ? 2'b11 : (c <= 9) ? 2'b01 : 2'b00;
         exp_din  = (c == 1) ? 8'h4A : 8'h00;
         exp_done = (c == 10);
         exp_busy = (c <= 9);
         if (in_ready[0] == 1'b0) ready_low++;
         checks++;
         if (sel[0] !== exp_sel || din[0] !== exp_din || done[0] !== exp_done || busy[0] !== exp_busy)
            $display("FAIL right_cyc%0d: got sel=%b din=%h done=%b busy=%b required %b %h %b %b",
                     c, sel[0], din[0], done[0], busy[0], exp_sel, exp_din, exp_done, exp_busy);
         else passes++;
         if (c == 2) begin
            checks++; if (q[0] !== 8'h4A) $display("FAIL right_qload: got %h required 4a", q[0]); else passes++;
         end
      end
      checks++; if (ready_low != 10) $display("FAIL right_ready_low: got %0d required 10", ready_low); else passes++;
      checks++; if (q[0] !== 8'h00) $display("FAIL right_qend: got %h required 00", q[0]); else passes++;
   endtask

   task automatic test_left();
      int         ready_low;
      logic [1:0] exp_sel;
      logic [7:0] exp_din;
      logic       exp_done;
      ready_low = 0;
      @(posedge clk); #1; in_data[1] = 8'hDA; in_dir[1] = 1'b1; in_valid[1] = 1'b1;
      @(posedge clk); #1; in_valid[1] = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp_sel  = (c == 1) ? 2'b11 : (c <= 4) ? 2'b10 : 2'b00;
         exp_din  = (c == 1) ? 8'hDA : 8'h00;
         exp_done = (c == 5);
         if (in_ready[1] == 1'b0) ready_low++;
         checks++;
         if (sel[1] !== exp_sel || din[1] !== exp_din || done[1] !== exp_done)
            $display("FAIL left_cyc%0d: got sel=%b din=%h done=%b required %b %h %b",
                     c, sel[1], din[1], done[1], exp_sel, exp_din, exp_done);
         else passes++;
      end
      checks++; if (ready_low != 5) $display("FAIL left_ready_low: got %0d required 5", ready_low); else passes++;
      checks++; if (q[1] !== 8'hD0) $display("FAIL left_qend: got %h required d0", q[1]); else passes++;
   endtask

   task automatic test_back_to_back();
      int first_load;
      int second_load;
      first_load  = -1;
      second_load = -1;
      @(posedge clk); #1; in_data[0] = 8'hEA; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_data[0] = 8'hEF;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (sel[0] == 2'b11) begin
            if (first_load < 0) begin
               first_load = c;
               checks++; if (din[0] !== 8'hEA) $display("FAIL b2b_din1: got %h required ea", din[0]); else passes++;
            end else begin
               second_load = c;
               in_valid[0] = 1'b0;
               checks++; if (din[0] !== 8'hEF) $display("FAIL b2b_din2: got %h required ef", din[0]); else passes++;
               break;
            end
         end
      end
      in_valid[0] = 1'b0;
      checks++; if (first_load != 1) $display("FAIL b2b_first: got cycle %0d required 1", first_load); else passes++;
      checks++;
      if (second_load - first_load != 11)
         $display("FAIL b2b_spacing: got %0d required 11", second_load - first_load);
      else passes++;
      for (int w = 0; w < 20 && in_ready[0] !== 1'b1; w++) @(negedge clk);
      checks++; if (in_ready[0] !== 1'b1) $display("FAIL b2b_drain: got ready=%b required 1", in_ready[0]); else passes++;
   endtask

   task automatic test_abort();
      int shifts;
      bit done_seen;
      shifts    = 0;
      done_seen = 1'b0;
      @(posedge clk); #1; in_data[0] = 8'h33; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1; abort[0] = 1'b1;
      @(negedge clk);
      checks++; if (sel[0] !== 2'b01) $display("FAIL abort_shift3: got sel=%b required 01", sel[0]); else passes++;
      @(posedge clk); #1; abort[0] = 1'b0; in_data[0] = 8'hFA; in_dir[0] = 1'b0; in_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (sel[0] !== 2'b00 || done[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0)
         $display("FAIL abort_idle: got sel=%b done=%b ready=%b busy=%b required 00 0 1 0",
                  sel[0], done[0], in_ready[0], busy[0]);
      else passes++;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (sel[0] !== 2'b11 || din[0] !== 8'hFA)
         $display("FAIL abort_reload: got sel=%b din=%h required 11 fa", sel[0], din[0]);
      else passes++;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (sel[0] == 2'b01) shifts++;
         if (done[0] == 1'b1) begin
            done_seen = 1'b1;
            break;
         end
      end
      checks++; if (!done_seen) $display("FAIL abort_next_done: got none required pulse"); else passes++;
      checks++; if (shifts != 8) $display("FAIL abort_next_shifts: got %0d required 8", shifts); else passes++;
      checks++; if (q[0] !== 8'h00) $display("FAIL abort_next_q: got %h required 00", q[0]); else passes++;
      @(negedge clk);
   endtask

   task automatic test_abort_in_idle();
      @(posedge clk); #1; in_data[0] = 8'h81; in_dir[0] = 1'b1; in_valid[0] = 1'b1; abort[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0; abort[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (sel[0] !== 2'b11 || din[0] !== 8'h81)
         $display("FAIL abort_idle_accept: got sel=%b din=%h required 11 81", sel[0], din[0]);
      else passes++;
      for (int w = 0; w < 20 && in_ready[0] !== 1'b1; w++) @(negedge clk);
      checks++; if (in_ready[0] !== 1'b1) $display("FAIL abort_idle_drain: got ready=%b required 1", in_ready[0]); else passes++;
   endtask

   task automatic test_shifts0();
      @(posedge clk); #1; in_data[2] = 8'h5A; in_dir[2] = 1'b1; in_valid[2] = 1'b1;
      @(posedge clk); #1; in_valid[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (sel[2] !== 2'b11 || din[2] !== 8'h5A || busy[2] !== 1'b1 || in_ready[2] !== 1'b0)
         $display("FAIL s0_load: got sel=%b din=%h busy=%b ready=%b required 11 5a 1 0",
                  sel[2], din[2], busy[2], in_ready[2]);
      else passes++;
      @(negedge clk);
      checks++;
      if (sel[2] !== 2'b00 || done[2] !== 1'b1 || busy[2] !== 1'b0)
         $display("FAIL s0_done: got sel=%b done=%b busy=%b required 00 1 0", sel[2], done[2], busy[2]);
      else passes++;
      @(negedge clk);
      checks++;
      if (in_ready[2] !== 1'b1 || done[2] !== 1'b0)
         $display("FAIL s0_idle: got ready=%b done=%b required 1 0", in_ready[2], done[2]);
      else passes++;
      checks++; if (q[2] !== 8'h5A) $display("FAIL s0_q: got %h required 5a", q[2]); else passes++;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0;
         in_dir[i]   = 1'b0;
         abort[i]    = 1'b0;
         in_data[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      test_reset();
      test_right();
      test_left();
      test_back_to_back();
      test_abort();
      test_abort_in_idle();
      test_shifts0();

      checks++;
      if (bad_sel_seen) $display("FAIL s0_no_shift: got shift command required none");
      else passes++;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
